// File: rtl/abc_stim_pkg.sv
// abc_stim_pkg: shared FSM states and pattern constants for the A/B/C stimulus generator.
package abc_stim_pkg;
   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, FINISH} state_e;
   localparam int NUM_PATTERNS = 8;
   localparam int IDX_W = 3;
endpackage

// File: rtl/abc_stimulus_gen_if.sv
// abc_stimulus_gen_if: A/B/C stimulus bus and y response of the 3-input target.
interface abc_stimulus_gen_if;
   logic A;
   logic B;
   logic C;
   logic y;
   modport master(output A, output B, output C, input y);
   modport slave(input A, input B, input C, output y);
endinterface

// File: rtl/abc_hold_timer.sv
// abc_hold_timer: counts 0..HOLD_CYCLES-1 while enabled and flags the last cycle of the window.
module abc_hold_timer #(
   parameter int HOLD_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   input  logic en_i,
   output logic last_o
);
   localparam int CW = $clog2(HOLD_CYCLES);
   logic [CW-1:0] cnt_q, cnt_d;
   assign last_o = cnt_q == CW'(HOLD_CYCLES - 1);
   always_comb cnt_d = clr_i ? '0 : en_i ? (last_o ? '0 : cnt_q + 1'b1) : cnt_q;
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
endmodule

// File: rtl/abc_stimulus_gen.sv
// abc_stimulus_gen: sweeps {A,B,C} over all 8 patterns, checks y against EXPECT, counts mismatches.
// Optional ABC_LOOP_EN: sweeps repeat back-to-back until a start pulse while busy requests a stop.
module abc_stimulus_gen
   import abc_stim_pkg::*;
#(
   parameter int                      HOLD_CYCLES = 4,
   parameter logic [NUM_PATTERNS-1:0] EXPECT      = 8'b1001_0110,
   parameter int                      ERR_W       = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   abc_stimulus_gen_if.master abc,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [IDX_W-1:0] cur_idx
);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PATTERNS - 1);
   state_e state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [ERR_W-1:0] err_q, err_d, err_chk;
   logic pass_q, pass_d, y_q, y_d, done_q, done_d, last;
`ifdef ABC_LOOP_EN
   logic stop_q, stop_d;
`endif
   abc_hold_timer #(.HOLD_CYCLES(HOLD_CYCLES)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .clr_i (state_q != DRIVE),
      .en_i  (state_q == DRIVE),
      .last_o(last)
   );
   assign busy    = state_q == DRIVE || state_q == CHECK;
   assign done    = done_q;
   assign pass    = pass_q;
   assign err_cnt = err_q;
   assign cur_idx = idx_q;
   assign {abc.A, abc.B, abc.C} = busy ? idx_q : '0;
   // y was captured at the end of the hold window, so the target had time to settle
   assign err_chk = (y_q != EXPECT[idx_q] && !(&err_q)) ? err_q + 1'b1 : err_q;
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = err_q;
      pass_d  = pass_q;
      y_d     = y_q;
      done_d  = 1'b0;
`ifdef ABC_LOOP_EN
      stop_d  = stop_q | (start & busy);
`endif
      case (state_q)
         IDLE: if (start) begin
            state_d = DRIVE;
            idx_d   = '0;
            err_d   = '0;
            pass_d  = 1'b0;
`ifdef ABC_LOOP_EN
            stop_d  = 1'b0;
`endif
         end
         DRIVE: if (last) begin
            y_d     = abc.y;
            state_d = CHECK;
         end
         CHECK: begin
            err_d = err_chk;
            if (idx_q == LAST_IDX) begin
               done_d = 1'b1;
               pass_d = err_chk == '0;
`ifdef ABC_LOOP_EN
               state_d = stop_d ? FINISH : DRIVE;
               if (!stop_d) begin
                  idx_d = '0;
                  err_d = '0;
               end
`else
               state_d = FINISH;
`endif
            end else begin
               idx_d   = idx_q + 1'b1;
               state_d = DRIVE;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         err_q   <= '0;
         pass_q  <= 1'b0;
         y_q     <= 1'b0;
         done_q  <= 1'b0;
`ifdef ABC_LOOP_EN
         stop_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         pass_q  <= pass_d;
         y_q     <= y_d;
         done_q  <= done_d;
`ifdef ABC_LOOP_EN
         stop_q  <= stop_d;
`endif
      end
   end
endmodule

// File: tb/tb_abc_stimulus_gen.sv
// tb_abc_stimulus_gen: scoreboard bench; target modelled as y = A^B^C with per-pattern fault injection.
module tb_abc_stimulus_gen;
   localparam int H = 4;
   localparam int EW = 2;
   localparam int SWEEP = 8 * (H + 1);
   typedef struct {
      int   err;
      logic pass;
      logic last;
   } exp_t;
   logic clk = 1'b0;
   logic rst, start;
   logic busy, done, pass;
   logic [EW-1:0] err_cnt;
   logic [2:0] cur_idx;
   abc_stimulus_gen_if bus();
   abc_stimulus_gen #(.HOLD_CYCLES(H), .ERR_W(EW)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .abc    (bus),
      .busy   (busy),
      .done   (done),
      .pass   (pass),
      .err_cnt(err_cnt),
      .cur_idx(cur_idx)
   );
   always #5 clk = ~clk;
   exp_t sb[$];
   int n_pass = 0, n_chk = 0, n_done = 0;
   logic [7:0] fault = '0;
   logic [2:0] abc_now, abc_seen = '0;
   int age = 100;
   logic noise = 1'b0;
   assign abc_now = {bus.A, bus.B, bus.C};
   // target settles H-1 cycles after a pattern change; before that y is noise
   assign bus.y = (age >= H - 1) ? ((^abc_now) ^ fault[abc_now]) : noise;
   always @(negedge clk) begin
      if (abc_now != abc_seen) begin
         abc_seen = abc_now;
         age = 0;
      end else age++;
      noise = 1'($urandom);
   end
   task automatic check(string name, int got, int want);
      n_chk++;
      if (got == want) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, got, want);
   endtask
   function automatic int model_err(logic [7:0] m);
      int c = $countones(m);
      return c > (1 << EW) - 1 ? (1 << EW) - 1 : c;
   endfunction
   task automatic push_exp(int err, logic p, logic last);
      exp_t e;
      e = '{err, p, last};
      sb.push_back(e);
   endtask
   int run = 0, bad;
   logic [2:0] seq[$];
   exp_t e;
   always @(negedge clk) begin
      if (rst) begin
         run = 0;
         seq.delete();
      end else begin
         if (done) begin
            n_done++;
            if (sb.size() == 0) check("unexpected_done", 1, 0);
            else begin
               e = sb.pop_front();
               check("sweep_len", run, SWEEP);
               bad = 0;
               foreach (seq[k]) if (int'(seq[k]) != k / (H + 1)) bad++;
               check("abc_sequence", bad, 0);
               check("err_cnt", int'(err_cnt), e.err);
               check("pass", int'(pass), int'(e.pass));
               check("busy_at_done", int'(busy), int'(!e.last));
               if (e.last) check("abc_idle_at_done", int'(abc_now), 0);
            end
            run = 0;
            seq.delete();
         end
         if (busy) begin
            run++;
            seq.push_back(abc_now);
         end
      end
   end
   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic wait_dones(int target);
      for (int i = 0; i < 4 * SWEEP && n_done < target; i++) @(negedge clk);
      check("done_seen", n_done, target);
   endtask
   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask
   task automatic sweep(logic [7:0] m);
      int base;
      base = n_done;
      fault = m;
      push_exp(model_err(m), m == 0, 1'b1);
      pulse_start();
`ifdef ABC_LOOP_EN
      tick(3 + $urandom_range(0, SWEEP - 10));
      pulse_start();
`endif
      wait_dones(base + 1);
      tick(3);
      check("err_hold", int'(err_cnt), model_err(m));
      check("pass_hold", int'(pass), int'(m == 0));
   endtask
   initial begin
      int base;
      rst = 1'b1;
      start = 1'b0;
      tick(3);
      check("reset_outs", int'({abc_now, busy, done, pass, err_cnt, cur_idx}), 0);
      rst = 1'b0;
      tick(2);
      sweep(8'h00);
      sweep(8'h20);
      sweep(8'hFF);
      sweep(8'h81);
      repeat (6) sweep(8'($urandom));
`ifndef ABC_LOOP_EN
      base = n_done;
      fault = '0;
      push_exp(0, 1'b1, 1'b1);
      pulse_start();
      for (int i = 0; i < SWEEP && cur_idx != 3'd2; i++) tick(1);
      check("reach_idx2", int'(cur_idx), 2);
      pulse_start();
      wait_dones(base + 1);
      tick(SWEEP);
      check("single_done", n_done, base + 1);
      check("idle_after_sweep", int'(busy), 0);
`else
      base = n_done;
      fault = 8'h04;
      push_exp(0, 1'b0, 1'b0);
      push_exp(1, 1'b0, 1'b1);
      pulse_start();
      wait_dones(base + 1);
      tick(5);
      check("busy_in_loop", int'(busy), 1);
      pulse_start();
      wait_dones(base + 2);
      tick(SWEEP);
      check("loop_dones", n_done, base + 2);
      check("loop_idle", int'(busy), 0);
`endif
      fault = '0;
      pulse_start();
      for (int i = 0; i < SWEEP && cur_idx != 3'd3; i++) tick(1);
      check("reach_idx3", int'(cur_idx), 3);
      rst = 1'b1;
      tick(1);
      check("rst_midsweep", int'({abc_now, busy, done, pass, err_cnt, cur_idx}), 0);
      rst = 1'b0;
      base = n_done;
      tick(2 * SWEEP);
      check("no_done_after_rst", n_done, base);
      check("scoreboard_empty", sb.size(), 0);
      sweep(8'h10);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/abc_stimulus_gen.md
Name: abc_stimulus_gen

Overview:
- Drives the three single-bit inputs A, B, C of the 3-input combinational test target, sweeping all 8 combinations.
- Samples the target's single-bit response y and checks it against a parameterised expected truth table.
- Reports pass/fail and a saturating mismatch count.
- It is the driving side of the A/B/C interface: the source that exercises the 3-input unit on board or in simulation.

Parameters:
- HOLD_CYCLES, 4: cycles each pattern is held; legal range ≥ 2.
- EXPECT, 8'b1001_0110: expected y per pattern; bit index = {A,B,C}.
- ERR_W, 4: width of the mismatch counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request one sweep; sampled high for one or more cycles.
- y  in  1  response of the target under test.
- A  out  1  stimulus bit 2 (MSB of pattern index).
- B  out  1  stimulus bit 1.
- C  out  1  stimulus bit 0 (LSB).
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  last completed sweep had zero mismatches.
- err_cnt  out  ERR_W  mismatch count of current/last sweep.
- cur_idx  out  3  pattern index currently driven.

Behaviour:
- Reset: A=B=C=0, busy=0, done=0, pass=0, err_cnt=0, cur_idx=0, FSM in IDLE, hold counter 0.
  - Reset applies in every state; reset mid-sweep aborts with no done pulse.
- FSM states: IDLE, DRIVE, CHECK, FINISH.
- IDLE:
  - start=1 → DRIVE next cycle.
  - In that cycle: busy=1, cur_idx=0, {A,B,C}=000, err_cnt cleared to 0, pass cleared to 0.
- DRIVE:
  - {A,B,C}=cur_idx.
  - Hold counter counts 0..HOLD_CYCLES-1.
  - When the counter reaches HOLD_CYCLES-1, y is sampled on that cycle's edge and the FSM goes to CHECK.
- CHECK (one cycle; outputs unchanged):
  - If sampled y ≠ EXPECT[cur_idx], err_cnt increments, saturating at all-ones.
  - If cur_idx=7 → FINISH.
  - Otherwise cur_idx+1, counter cleared, → DRIVE.
- Per pattern: HOLD_CYCLES+1 cycles. Full sweep: 8*(HOLD_CYCLES+1) cycles from the first busy cycle to the FINISH cycle.
- FINISH (one cycle):
  - done=1, busy=0, A=B=C=0, pass=(err_cnt==0 after the final check).
  - Then → IDLE.
  - pass and err_cnt hold until the next start.
- start while busy: ignored (no restart, no queueing).
- start in the FINISH cycle: ignored. start in IDLE the following cycle: accepted.
- Sampling y only at the end of the hold window tolerates target settle time of up to HOLD_CYCLES-1 cycles.
- Counter widths: hold counter $clog2(HOLD_CYCLES); cur_idx 3 bits; no wrap inside a sweep.

Optional Feature:
- Macro: ABC_LOOP_EN.
- Defined:
  - After CHECK of idx 7, the FSM pulses done, updates pass for that sweep, clears err_cnt, and wraps cur_idx to 0 back into DRIVE.
  - busy stays 1.
  - A start pulse while busy requests stop: the current sweep completes, then the FSM returns to IDLE with busy=0.
- Not defined: single-sweep behaviour as above. start while busy is ignored.

Decomposition:
- Package abc_stim_pkg holds:
  - the state enum (IDLE, DRIVE, CHECK, FINISH);
  - NUM_PATTERNS=8;
  - IDX_W=3.
- Sub-module abc_hold_timer: HOLD_CYCLES-parameterised counter with clear and enable inputs and a last-cycle flag output.
- The top level instantiates one abc_hold_timer alongside the FSM and checker.

Test Plan:
- Reset behaviour: rst held high during a sweep at cur_idx=3 → next cycle all outputs 0, FSM in IDLE, no done pulse.
- Golden sweep: HOLD_CYCLES=4; bench models y = A^B^C; start pulsed → A/B/C step 000..111, each held 4 cycles.
  - done pulses exactly 40 cycles after the first busy cycle.
  - pass=1, err_cnt=0.
- Single fault: bench forces y wrong for idx 5 only → err_cnt=1, pass=0 at done.
- Saturation: ERR_W=2, bench drives y = ~expected → err_cnt saturates at 3, pass=0.
- start while busy: pulse start at cur_idx=2 → sweep unaffected, exactly one done pulse.
- ABC_LOOP_EN: two sweeps run back-to-back with done pulsing twice and busy high throughout; start pulsed during the 2nd sweep → busy=0 after the 2nd done.
